// File: rtl/pc_flow_ctrl.sv
// rtl/pc_flow_ctrl.sv - PC register, ID hazard stalls and imem req/ack redirect sequencing.
// Optional PC_FLOW_STATS_EN adds stall_cnt/flush_cnt event counters.
module pc_flow_ctrl #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_branch,
    input  logic        id_eq,
    input  logic        id_jump,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        mem_memread,
    input  logic [4:0]  mem_rd,
    input  logic [29:0] npc_in,
    input  logic        imem_ack,
    output logic [29:0] pc,
    output logic        npc_branch_ok,
    output logic        npc_jump,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        if_flush,
    output logic        idex_bubble,
    output logic        imem_req
`ifdef PC_FLOW_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, WAIT_REDIR} state_t;

    state_t      state, state_nxt;
    logic [29:0] pend_pc, pend_nxt, pc_nxt;
    logic        load_use, br_haz, stall, taken;

    // r0 is never a real producer, so it can never create a hazard
    function automatic logic match(input logic [4:0] r);
        return (r != 5'd0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
    endfunction

    assign load_use = ex_memread & match(ex_rd);
    assign br_haz   = id_branch & ((ex_regwrite & ~ex_memread & match(ex_rd)) |
                                   (mem_memread & match(mem_rd)));
    assign stall    = load_use | br_haz;
    assign taken    = ~stall & ((id_branch & id_eq) | id_jump);

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        pend_nxt      = pend_pc;
        npc_branch_ok = 1'b0;
        npc_jump      = 1'b0;
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        if_flush      = 1'b0;
        idex_bubble   = 1'b0;
        imem_req      = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                imem_req      = 1'b1;
                npc_branch_ok = ~stall & id_branch & id_eq;
                npc_jump      = ~stall & id_jump & ~(~stall & id_branch & id_eq);
                if (stall) begin
                    idex_bubble = 1'b1;
                end else if (imem_ack) begin
                    pc_nxt     = npc_in;
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    if_flush   = taken;
                end else if (!taken) begin
                    idex_bubble = 1'b1;
                end else begin
                    // Fetch address must stay stable until ack; park the target
                    pend_nxt  = npc_in;
                    if_flush  = 1'b1;
                    state_nxt = WAIT_REDIR;
                end
            end
            WAIT_REDIR: begin
                imem_req    = 1'b1;
                idex_bubble = 1'b1;
                if (imem_ack) begin
                    pc_nxt    = pend_pc;
                    pc_write  = 1'b1;
                    if_flush  = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
        if (!rst_n) begin
            npc_branch_ok = 1'b0;
            npc_jump      = 1'b0;
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            if_flush      = 1'b0;
            idex_bubble   = 1'b0;
            imem_req      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            pend_pc <= 30'd0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pend_pc <= pend_nxt;
        end
    end

`ifdef PC_FLOW_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall)    stall_cnt <= stall_cnt + 32'd1;
            if (if_flush) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb/tb_pc_flow_ctrl.sv - directed and randomized checks of pc_flow_ctrl against a reference model.
module tb_pc_flow_ctrl;

    localparam logic [29:0] RST_PC = 30'h0000_0C00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        id_uses_rt, id_branch, id_eq, id_jump;
    logic        ex_regwrite, ex_memread, mem_memread, imem_ack;
    logic [29:0] npc_in;
    logic [29:0] pc;
    logic        npc_branch_ok, npc_jump, pc_write, ifid_write, if_flush, idex_bubble, imem_req;

    int checks = 0;
    int errors = 0;

    logic [29:0] m_pc, m_pend;
    int          m_mode = -1;  // -1 unknown, 0 boot, 1 run, 2 waiting for redirect ack

    logic s_brok, s_jmp, s_pw, s_ifid, s_flush, s_bub, s_req;

    always #5 clk = ~clk;

    pc_flow_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_eq(id_eq), .id_jump(id_jump),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_rd(mem_rd),
        .npc_in(npc_in), .imem_ack(imem_ack),
        .pc(pc), .npc_branch_ok(npc_branch_ok), .npc_jump(npc_jump),
        .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
        .idex_bubble(idex_bubble), .imem_req(imem_req)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] r);
        return (r != 0) && (r == id_rs || (id_uses_rt && r == id_rt));
    endfunction

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_branch = 0; id_eq = 0; id_jump = 0;
        ex_regwrite = 0; ex_memread = 0; ex_rd = 0; mem_memread = 0; mem_rd = 0;
    endtask

    // One clock: check combinational outputs mid-cycle, then the registered pc after the edge
    task automatic step();
        bit st, tk, e_brok, e_jmp, e_pw, e_ifid, e_flush, e_bub, e_req;
        logic [29:0] n_pc, n_pend;
        int n_mode;
        @(negedge clk); #1;
        st = (ex_memread && hit(ex_rd)) ||
             (id_branch && ((ex_regwrite && !ex_memread && hit(ex_rd)) || (mem_memread && hit(mem_rd))));
        tk = !st && ((id_branch && id_eq) || id_jump);
        {e_brok, e_jmp, e_pw, e_ifid, e_flush, e_bub, e_req} = '0;
        n_pc = m_pc; n_pend = m_pend; n_mode = m_mode;
        if (!rst_n) begin
            n_pc = RST_PC; n_pend = 0; n_mode = 0;
        end else if (m_mode == 0) begin
            n_mode = 1;
        end else if (m_mode == 1) begin
            e_req  = 1;
            e_brok = !st && id_branch && id_eq;
            e_jmp  = !st && id_jump && !e_brok;
            if (st) e_bub = 1;
            else if (imem_ack) begin
                e_pw = 1; e_ifid = 1; e_flush = tk; n_pc = npc_in;
            end else if (!tk) e_bub = 1;
            else begin
                e_flush = 1; n_pend = npc_in; n_mode = 2;
            end
        end else if (m_mode == 2) begin
            e_req = 1; e_bub = 1;
            if (imem_ack) begin
                e_pw = 1; e_flush = 1; n_pc = m_pend; n_mode = 1;
            end
        end
        s_brok = npc_branch_ok; s_jmp = npc_jump; s_pw = pc_write; s_ifid = ifid_write;
        s_flush = if_flush; s_bub = idex_bubble; s_req = imem_req;
        chk("npc_branch_ok", 32'(npc_branch_ok), 32'(e_brok));
        chk("npc_jump", 32'(npc_jump), 32'(e_jmp));
        chk("pc_write", 32'(pc_write), 32'(e_pw));
        chk("ifid_write", 32'(ifid_write), 32'(e_ifid));
        chk("if_flush", 32'(if_flush), 32'(e_flush));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        chk("imem_req", 32'(imem_req), 32'(e_req));
        if (m_mode >= 0) chk("pc_mid", 32'(pc), 32'(m_pc));
        @(posedge clk); #1;
        m_pc = n_pc; m_pend = n_pend; m_mode = n_mode;
        chk("pc_edge", 32'(pc), 32'(m_pc));
    endtask

    initial begin
        clear_inputs();
        rst_n = 0; imem_ack = 0; npc_in = 0;
        step(); step();
        chk("reset_pc", 32'(pc), 32'(RST_PC));
        chk("reset_req", 32'(s_req), 32'd0);

        // Sequential fetch out of reset: BOOT, then RUN, both at RESET_PC
        rst_n = 1; imem_ack = 1; npc_in = m_pc + 30'd1;
        step();
        chk("boot_pc", 32'(pc), 32'h0C00);
        chk("boot_req", 32'(s_req), 32'd0);
        npc_in = m_pc + 30'd1; step();
        chk("seq_pc1", 32'(pc), 32'h0C01);
        npc_in = m_pc + 30'd1; step();
        chk("seq_pc2", 32'(pc), 32'h0C02);

        // Load-use
        ex_memread = 1; ex_rd = 8; id_rs = 8; npc_in = m_pc + 30'd1;
        step();
        chk("lu_pc_write", 32'(s_pw), 32'd0);
        chk("lu_ifid", 32'(s_ifid), 32'd0);
        chk("lu_bubble", 32'(s_bub), 32'd1);
        chk("lu_pc_held", 32'(pc), 32'h0C02);

        // lw $9 then beq on rt=9: two stall cycles
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 9;
        id_branch = 1; id_uses_rt = 1; id_rs = 3; id_rt = 9; id_eq = 1;
        step();
        chk("lwbeq_stall1", 32'(s_bub), 32'd1);
        ex_memread = 0; ex_regwrite = 0; ex_rd = 0; mem_memread = 1; mem_rd = 9;
        step();
        chk("lwbeq_stall2", 32'(s_bub), 32'd1);
        chk("lwbeq_no_br", 32'(s_brok), 32'd0);
        mem_memread = 0; mem_rd = 0; npc_in = m_pc + 30'd5;
        step();
        chk("lwbeq_br_ok", 32'(s_brok), 32'd1);
        chk("lwbeq_flush", 32'(s_flush), 32'd1);
        chk("lwbeq_pc", 32'(pc), 32'h0C07);

        // Jump with ack
        clear_inputs();
        id_jump = 1; npc_in = 30'h100;
        step();
        chk("j_sel", 32'(s_jmp), 32'd1);
        chk("j_flush", 32'(s_flush), 32'd1);
        chk("j_pc", 32'(pc), 32'h100);

        // Taken beq while imem withholds ack
        clear_inputs();
        id_branch = 1; id_eq = 1; imem_ack = 0; npc_in = 30'h0C10;
        step();
        chk("redir_flush", 32'(s_flush), 32'd1);
        chk("redir_bubble", 32'(s_bub), 32'd0);
        chk("redir_pc_held", 32'(pc), 32'h100);
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            npc_in = 30'($urandom);
            step();
            chk("wait_pc_held", 32'(pc), 32'h100);
            chk("wait_no_pw", 32'(s_pw), 32'd0);
        end
        imem_ack = 1;
        step();
        chk("wait_ack_flush", 32'(s_flush), 32'd1);
        chk("wait_ack_pc", 32'(pc), 32'h0C10);

        // Reset while a redirect is pending
        id_branch = 1; id_eq = 1; imem_ack = 0; npc_in = 30'h2222;
        step();
        clear_inputs();
        rst_n = 0;
        step();
        chk("rst_wait_pc", 32'(pc), 32'(RST_PC));
        rst_n = 1; imem_ack = 1; npc_in = m_pc + 30'd1;
        step();
        chk("rst_boot_req", 32'(s_req), 32'd0);
        npc_in = m_pc + 30'd1;
        step();
        chk("rst_no_pend", 32'(pc), 32'h0C01);

        // Randomized traffic with small register numbers to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            mem_rd      = 5'($urandom_range(0, 3));
            id_uses_rt  = 1'($urandom);
            id_branch   = 1'($urandom);
            id_eq       = 1'($urandom);
            id_jump     = ($urandom_range(0, 3) == 0);
            ex_regwrite = 1'($urandom);
            ex_memread  = 1'($urandom);
            mem_memread = 1'($urandom);
            imem_ack    = ($urandom_range(0, 2) != 0);
            npc_in      = 30'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
